reg_file_wb_stage: RTL
======================

Name: reg_file_wb_stage

Overview:
- Write-back stage that sits directly downstream of the register-file write-address controller.
- Consumes the controller's write enable and rt/rd select, plus the rt/rd fields, ALU result and load data.
- Registers the selected write into a MEM/WB pipeline register, then commits it to a 32x32 register file.
- Provides two combinational read ports that bypass the pending write-back.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width
- NREGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold the WB pipeline register
- w_en  in  1  write enable from the address controller
- w_waddr_sel  in  1  1 = write to rt, 0 = write to rd; may be X when w_en=0
- w_mem_op  in  1  1 = write mem_rdata, 0 = write alu_result
- rt  in  ADDR_W  instruction rt field
- rd  in  ADDR_W  instruction rd field
- alu_result  in  DATA_W  ALU output
- mem_rdata  in  DATA_W  data-memory load data
- raddr_a  in  ADDR_W  read port A address
- raddr_b  in  ADDR_W  read port B address
- rdata_a  out  DATA_W  read port A data
- rdata_b  out  DATA_W  read port B data
- wb_valid  out  1  pending write-back valid (for upstream forwarding)
- wb_addr  out  ADDR_W  pending write-back address
- wb_data  out  DATA_W  pending write-back data

Behaviour:
- Reset is asynchronous and active-high:
  - wb_valid=0, wb_addr=0, wb_data=0.
  - All NREGS registers cleared to 0.
  - rdata_a/b therefore read 0.
  - Reset asserted mid-operation discards any pending write; nothing commits on the edge where reset deasserts.
- Address select (combinational):
  - sel_addr = w_waddr_sel ? rt : rd when w_en=1.
  - Forced to 0 when w_en=0, so an X on w_waddr_sel never reaches state.
- Data select: sel_data = w_mem_op ? mem_rdata : alu_result.
- WB register update, at the rising edge with stall=0:
  - wb_valid <= w_en & (sel_addr != 0)
  - wb_addr <= sel_addr
  - wb_data <= sel_data
- WB register with stall=1: all three fields hold.
- Commit: at every rising edge with wb_valid=1, regs[wb_addr] <= wb_data.
  - The write is idempotent, so a stalled entry rewriting the same value is legal.
- Latency:
  - Inputs sampled at edge N reach wb_* after edge N.
  - The register array is updated at edge N+1.
  - Reads see the new value from just after edge N, via the bypass.
- Register 0:
  - Never written; w_en to address 0 yields wb_valid=0.
  - Reads of address 0 always return 0, with no bypass.
- Read ports (combinational):
  - rdata_x = wb_data if wb_valid and wb_addr==raddr_x and raddr_x!=0; otherwise regs[raddr_x].
  - Both ports may bypass simultaneously and may read the same address.
- Back-to-back writes to the same register: the later entry overwrites wb_*; the earlier entry has already committed at the intervening edge. No write is lost.
- w_en=0 with stall=0 clears wb_valid (a bubble).
- X on w_mem_op while w_en=0 may propagate into wb_data only. wb_data is a don't-care whenever wb_valid=0.

Decomposition:
- Shared package (cpu_pkg), holding:
  - DATA_W, ADDR_W, NREGS
  - REG_ZERO = 0
  - WADDR_SEL_RT = 1, WADDR_SEL_RD = 0
  - WDATA_SEL_MEM = 1, WDATA_SEL_ALU = 0
- One sub-module, reg_file_array: storage, async clear, a single write port, and two raw combinational read ports.
- The top level keeps the select muxes, the WB register and the bypass.

Test Plan:
1. Reset:
   - Stimulus: assert reset mid-run after writing r5=0x1234, with wb_valid=1 pending for r6; deassert reset, then read r5 and r6.
   - Required: wb_valid=0 immediately, without a clock edge; rdata=0 for both registers; r6 never committed.
2. ALU write to rd:
   - Stimulus: w_en=1, w_waddr_sel=0, rd=7, w_mem_op=0, alu_result=0xDEADBEEF.
   - Required: wb_valid=1, wb_addr=7 after edge N; raddr_a=7 returns 0xDEADBEEF via bypass after edge N; same value from the array after edge N+1 with w_en=0.
3. Load to rt:
   - Stimulus: w_en=1, w_waddr_sel=1, rt=3, rd=9, w_mem_op=1, mem_rdata=0x00000042.
   - Required: r3=0x42; r9 unchanged.
4. r0 and X select:
   - Stimulus: w_en=1 with rt=0 and sel=1, alu_result=0xFFFFFFFF; then w_en=0 with w_waddr_sel=X.
   - Required: wb_valid=0 in both cases; raddr_a=0 reads 0; no register changes.
5. Stall:
   - Stimulus: write r4=0xA with stall=1 held for 3 cycles while the inputs change to r4=0xB.
   - Required: wb_data stays 0xA; r4=0xA; after stall drops, r4=0xB.
6. Back-to-back writes with dual read:
   - Stimulus: r10=1 then r10=2 on consecutive cycles, with raddr_a=raddr_b=10.
   - Required: both ports read 1 then 2, with no stale cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, the zero-register address and the write-back select encodings.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    WADDR_SEL_RD = 1'b0,
    WADDR_SEL_RT = 1'b1
  } waddr_sel_e;

  typedef enum logic {
    WDATA_SEL_ALU = 1'b0,
    WDATA_SEL_MEM = 1'b1
  } wdata_sel_e;

endpackage

// File: rtl/reg_file_array.sv
// Architectural register storage: async clear, one write port, two raw read ports.
module reg_file_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/reg_file_wb_stage.sv
// MEM/WB pipeline register feeding the register file, with read ports that
// bypass the pending write-back so a write is visible right after it is captured.
module reg_file_wb_stage
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              w_en,
  input  logic              w_waddr_sel,
  input  logic              w_mem_op,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] raw_a;
  logic [DATA_W-1:0] raw_b;

  // w_en gates the address first so an undefined select never reaches state.
  always_comb begin
    sel_addr = REG_ZERO;
    if (w_en) begin
      sel_addr = (w_waddr_sel == WADDR_SEL_RT) ? rt : rd;
    end
    sel_data = (w_mem_op == WDATA_SEL_MEM) ? mem_rdata : alu_result;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (!stall) begin
      wb_valid <= w_en && (sel_addr != REG_ZERO);
      wb_addr  <= sel_addr;
      wb_data  <= sel_data;
    end
  end

  reg_file_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_valid),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

  always_comb begin
    rdata_a = raw_a;
    rdata_b = raw_b;
    if (raddr_a == REG_ZERO) begin
      rdata_a = '0;
    end else if (wb_valid && (wb_addr == raddr_a)) begin
      rdata_a = wb_data;
    end
    if (raddr_b == REG_ZERO) begin
      rdata_b = '0;
    end else if (wb_valid && (wb_addr == raddr_b)) begin
      rdata_b = wb_data;
    end
  end

endmodule
